stage_mem: RTL and testbench

STAGE_MEM -- requirements
Module: stage_mem

---
 rtl/stage_mem.sv | 170 +++++++++++++++++
 tb/tb_stage_mem.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/stage_mem.sv
// Pipeline memory stage: passes ALU results straight to write-back, runs
// aligned loads/stores over a simple req/ack bus with a cycle timeout, and
// flags misaligned accesses and bus errors on a registered result port.
module stage_mem #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_we,
  input  logic [4:0]  in_waddr,
  input  logic [31:0] in_wdata,
  input  logic [2:0]  in_memop,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_sdata,
  output logic        stall_o,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic        out_we,
  output logic [4:0]  out_waddr,
  output logic [31:0] out_wdata,
  output logic        exc_misalign,
  output logic        exc_buserr
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [2:0] OP_LW  = 3'd1;
  localparam logic [2:0] OP_LB  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_SW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;

  // Last BUSY count value that may still wait for an ack.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_reg;
  logic [2:0]  op_reg;
  logic        we_reg;
  logic [4:0]  waddr_reg;
  logic [31:0] addr_reg;
  logic [15:0] count_reg;

  logic        in_is_mem;
  logic        in_is_store;
  logic        in_misalign;
  logic        op_is_load;
  logic [7:0]  rd_byte;
  logic [31:0] load_data;

  // The bus request is nothing more than the BUSY state register.
  assign stall_o = (state_reg == BUSY);
  assign mem_req = (state_reg == BUSY);

  // Decode the incoming op; codes 6-7 fall through as plain ALU results.
  always_comb begin
    in_is_mem   = (in_memop >= OP_LW) && (in_memop <= OP_SB);
    in_is_store = (in_memop == OP_SW) || (in_memop == OP_SB);
    in_misalign = ((in_memop == OP_LW) || (in_memop == OP_SW)) && (in_addr[1:0] != 2'b00);
  end

  // Pick the addressed byte lane and shape the load result.
  always_comb begin
    op_is_load = (op_reg == OP_LW) || (op_reg == OP_LB) || (op_reg == OP_LBU);
    case (addr_reg[1:0])
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    case (op_reg)
      OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_data = {24'd0, rd_byte};
      default: load_data = mem_rdata;
    endcase
  end

  // Control FSM plus all registered bus and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      op_reg       <= 3'd0;
      we_reg       <= 1'b0;
      waddr_reg    <= 5'd0;
      addr_reg     <= 32'd0;
      count_reg    <= 16'd0;
      mem_we       <= 1'b0;
      mem_be       <= 4'd0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      out_valid    <= 1'b0;
      out_we       <= 1'b0;
      out_waddr    <= 5'd0;
      out_wdata    <= 32'd0;
      exc_misalign <= 1'b0;
      exc_buserr   <= 1'b0;
    end else begin
      out_valid    <= 1'b0;
      exc_misalign <= 1'b0;
      exc_buserr   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            if (!in_is_mem) begin
              out_valid <= 1'b1;
              out_we    <= in_we;
              out_waddr <= in_waddr;
              out_wdata <= in_wdata;
            end else if (in_misalign) begin
              // Report the faulting address in place of a result.
              out_valid    <= 1'b1;
              out_we       <= 1'b0;
              out_waddr    <= in_waddr;
              out_wdata    <= in_addr;
              exc_misalign <= 1'b1;
            end else begin
              state_reg <= BUSY;
              op_reg    <= in_memop;
              we_reg    <= in_we;
              waddr_reg <= in_waddr;
              addr_reg  <= in_addr;
              count_reg <= 16'd0;
              mem_we    <= in_is_store;
              mem_addr  <= {in_addr[31:2], 2'b00};
              if (in_memop == OP_SB) begin
                mem_be    <= 4'b0001 << in_addr[1:0];
                mem_wdata <= {4{in_sdata[7:0]}};
              end else begin
                mem_be    <= 4'b1111;
                mem_wdata <= in_sdata;
              end
            end
          end
        end
        BUSY: begin
          // An ack in the expiry cycle still counts as a normal completion.
          if (mem_ack) begin
            state_reg <= IDLE;
            mem_we    <= 1'b0;
            mem_be    <= 4'd0;
            out_valid <= 1'b1;
            out_waddr <= waddr_reg;
            out_we    <= op_is_load ? we_reg : 1'b0;
            // Stores have no result; the address is reported for tracing.
            out_wdata <= op_is_load ? load_data : addr_reg;
          end else if (count_reg == CNT_LAST) begin
            state_reg  <= IDLE;
            mem_we     <= 1'b0;
            mem_be     <= 4'd0;
            out_valid  <= 1'b1;
            out_we     <= 1'b0;
            out_waddr  <= waddr_reg;
            out_wdata  <= addr_reg;
            exc_buserr <= 1'b1;
          end else begin
            count_reg <= count_reg + 16'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Bench for stage_mem: table of transactions driven through the stage with a
// small memory responder; expected write-back results are queued when an
// operation is issued and compared whenever out_valid fires.
module tb_stage_mem;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_we = 1'b0;
  logic [4:0]  in_waddr = 5'd0;
  logic [31:0] in_wdata = 32'd0;
  logic [2:0]  in_memop = 3'd0;
  logic [31:0] in_addr = 32'd0;
  logic [31:0] in_sdata = 32'd0;
  logic        stall_o;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        out_valid;
  logic        out_we;
  logic [4:0]  out_waddr;
  logic [31:0] out_wdata;
  logic        exc_misalign;
  logic        exc_buserr;

  stage_mem #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_we(in_we), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .in_memop(in_memop), .in_addr(in_addr), .in_sdata(in_sdata),
    .stall_o(stall_o),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_we(out_we), .out_waddr(out_waddr), .out_wdata(out_wdata),
    .exc_misalign(exc_misalign), .exc_buserr(exc_buserr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          ack_at;   // BUSY cycle (1-based) carrying the ack, 0 = never
    logic        bus;      // a bus transfer is expected
    logic [3:0]  be;
    logic        mwe;
    logic [31:0] mwdata;
    logic        ewe;
    logic [31:0] ewdata;
    logic        emis;
    logic        eberr;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare every write-back pulse against the oldest queued expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid: got out_valid=1 expected no result");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("wb_result", {27'd0, out_we, out_waddr, out_wdata, exc_misalign, exc_buserr},
              {27'd0, e.we, e.waddr, e.wdata, e.mis, e.berr});
        $display("result: we=%0d waddr=%0d wdata=0x%08h mis=%0d berr=%0d",
                 out_we, out_waddr, out_wdata, exc_misalign, exc_buserr);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   n;
    int   busy;
    int   exp_busy;
    @(negedge clk);
    check("stall_idle", {63'd0, stall_o}, 64'd0);
    in_valid = 1'b1;
    in_memop = v.op;
    in_we    = v.we;
    in_waddr = v.waddr;
    in_wdata = v.wdata;
    in_addr  = v.addr;
    in_sdata = v.sdata;
    e.we = v.ewe; e.waddr = v.waddr; e.wdata = v.ewdata; e.mis = v.emis; e.berr = v.eberr;
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    if (!v.bus) begin
      check("no_mem_req", {63'd0, mem_req}, 64'd0);
      check("direct_latency", {63'd0, out_valid}, 64'd1);
    end else begin
      check("mem_addr", {32'd0, mem_addr}, {32'd0, v.addr[31:2], 2'b00});
      check("mem_be", {60'd0, mem_be}, {60'd0, v.be});
      check("mem_we", {63'd0, mem_we}, {63'd0, v.mwe});
      if (v.mwe) check("mem_wdata", {32'd0, mem_wdata}, {32'd0, v.mwdata});
      busy = 0;
      n = 1;
      while (mem_req === 1'b1 && n <= 20) begin
        busy++;
        check("stall_busy", {63'd0, stall_o}, 64'd1);
        if (n == v.ack_at) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
        end
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'hA5A5_5A5A;
        n++;
      end
      exp_busy = (v.ack_at == 0) ? TIMEOUT : v.ack_at;
      check("busy_cycles", 64'(busy), 64'(exp_busy));
      check("done_latency", {63'd0, out_valid}, 64'd1);
    end
    $display("txn op=%0d addr=0x%08h done", v.op, v.addr);
  endtask

  initial begin
    //          op  we waddr wdata          addr           sdata          rdata          ack bus be       mwe mwdata         ewe ewdata         mis berr
    vecs[0]  = '{3'd0, 1, 5'd5,  32'h0000_00FF, 32'h0,         32'h0,         32'h0,         0, 0, 4'b0000, 0, 32'h0,         1, 32'h0000_00FF, 0, 0};
    vecs[1]  = '{3'd2, 1, 5'd7,  32'h0,         32'h0000_1003, 32'h0,         32'h8033_2211, 2, 1, 4'b1111, 0, 32'h0,         1, 32'hFFFF_FF80, 0, 0};
    vecs[2]  = '{3'd3, 1, 5'd7,  32'h0,         32'h0000_1003, 32'h0,         32'h8033_2211, 2, 1, 4'b1111, 0, 32'h0,         1, 32'h0000_0080, 0, 0};
    vecs[3]  = '{3'd5, 1, 5'd2,  32'h0,         32'h0000_2001, 32'h1234_56AB, 32'h0,         1, 1, 4'b0010, 1, 32'hABAB_ABAB, 0, 32'h0000_2001, 0, 0};
    vecs[4]  = '{3'd1, 1, 5'd4,  32'h0,         32'h0000_3002, 32'h0,         32'h0,         0, 0, 4'b0000, 0, 32'h0,         0, 32'h0000_3002, 1, 0};
    vecs[5]  = '{3'd4, 0, 5'd3,  32'h0,         32'h0000_4000, 32'hCAFE_F00D, 32'h0,         0, 1, 4'b1111, 1, 32'hCAFE_F00D, 0, 32'h0000_4000, 0, 1};
    vecs[6]  = '{3'd4, 0, 5'd3,  32'h0,         32'h0000_4004, 32'h1122_3344, 32'h0,         4, 1, 4'b1111, 1, 32'h1122_3344, 0, 32'h0000_4004, 0, 0};
    vecs[7]  = '{3'd1, 1, 5'd9,  32'h0,         32'h0000_5000, 32'h0,         32'hDEAD_BEEF, 1, 1, 4'b1111, 0, 32'h0,         1, 32'hDEAD_BEEF, 0, 0};
    vecs[8]  = '{3'd2, 1, 5'd10, 32'h0,         32'h0000_6001, 32'h0,         32'h0000_7F00, 1, 1, 4'b1111, 0, 32'h0,         1, 32'h0000_007F, 0, 0};
    vecs[9]  = '{3'd6, 1, 5'd12, 32'h1234_5678, 32'h0000_0001, 32'h0,         32'h0,         0, 0, 4'b0000, 0, 32'h0,         1, 32'h1234_5678, 0, 0};
    vecs[10] = '{3'd4, 1, 5'd13, 32'h0,         32'h0000_7001, 32'h0,         32'h0,         0, 0, 4'b0000, 0, 32'h0,         0, 32'h0000_7001, 1, 0};
    vecs[11] = '{3'd2, 0, 5'd14, 32'h0,         32'h0000_6002, 32'h0,         32'h00AB_0000, 3, 1, 4'b1111, 0, 32'h0,         0, 32'hFFFF_FFAB, 0, 0};
    vecs[12] = '{3'd5, 0, 5'd15, 32'h0,         32'h0000_2003, 32'h0000_005A, 32'h0,         2, 1, 4'b1000, 1, 32'h5A5A_5A5A, 0, 32'h0000_2003, 0, 0};

    // Reset state: every output low while rst is held.
    #1;
    check("reset_outputs",
          {stall_o, mem_req, mem_we, mem_be, mem_addr[15:0], mem_wdata[15:0], out_valid, out_we,
           out_waddr, out_wdata[15:0], exc_misalign, exc_buserr},
          64'd0);
    check("reset_upper", {mem_addr[31:16], mem_wdata[31:16], out_wdata[31:16], 16'd0}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Stray acks while idle must not produce anything.
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_2222;
    repeat (2) begin
      @(negedge clk);
      check("idle_ack_out_valid", {63'd0, out_valid}, 64'd0);
      check("idle_ack_mem_req", {63'd0, mem_req}, 64'd0);
    end
    mem_ack = 1'b0;
    $display("txn idle ack ignored");

    // Reset in the second BUSY cycle abandons the load silently.
    @(negedge clk);
    in_valid = 1'b1;
    in_memop = 3'd1;
    in_we    = 1'b1;
    in_waddr = 5'd20;
    in_addr  = 32'h0000_8000;
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_busy1_req", {63'd0, mem_req}, 64'd1);
    @(negedge clk);
    check("abort_busy2_req", {63'd0, mem_req}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_req_async", {63'd0, mem_req}, 64'd0);
    check("abort_stall_async", {63'd0, stall_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check("abort_no_out", {63'd0, out_valid}, 64'd0);
    $display("txn reset during busy");
    run_vec(vecs[0]);
    run_vec(vecs[7]);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
